// File: rtl/imem_fetch_unit.sv
// Instruction-fetch initiator: owns the fetch PC, buffers two ROM words with their PCs, and handles redirects.
// Optional FETCH_PERF_EN adds fetch_cnt/stall_cnt performance counters.
module imem_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          ADDR_W   = 11
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic              fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    logic [31:0] r_fetch_pc, r_pc0, r_instr0, r_pc1, r_instr1;
    logic [1:0]  r_count;
    logic        r_valid, r_fault;

    logic [31:0] w_fetch_pc, w_pc0, w_instr0, w_pc1, w_instr1;
    logic [1:0]  w_count;
    logic        w_fault, w_pop, w_enq;

    assign w_pop     = r_valid && out_ready;
    assign w_enq     = !redirect_valid && !r_fault && ((r_count != 2'd2) || w_pop);
    assign imem_addr = r_fetch_pc[ADDR_W+1:2];
    assign out_valid = r_valid;
    assign out_instr = r_instr0;
    assign out_pc    = r_pc0;
    assign fault     = r_fault;

    always_comb begin
        w_fetch_pc = r_fetch_pc;
        w_pc0      = r_pc0;
        w_instr0   = r_instr0;
        w_pc1      = r_pc1;
        w_instr1   = r_instr1;
        w_count    = r_count;
        w_fault    = r_fault;
        if (redirect_valid) begin
            // Redirect flushes everything, including a head consumed this same edge.
            w_count    = 2'd0;
            w_fetch_pc = redirect_pc;
            w_fault    = |redirect_pc[1:0];
        end else begin
            if (w_enq) begin
                w_fetch_pc = r_fetch_pc + 32'd4;
            end
            unique case (r_count)
                2'd0: begin
                    if (w_enq) begin
                        w_pc0    = r_fetch_pc;
                        w_instr0 = imem_instr;
                        w_count  = 2'd1;
                    end
                end
                2'd1: begin
                    if (w_pop && w_enq) begin
                        w_pc0    = r_fetch_pc;
                        w_instr0 = imem_instr;
                    end else if (w_pop) begin
                        w_count = 2'd0;
                    end else if (w_enq) begin
                        w_pc1    = r_fetch_pc;
                        w_instr1 = imem_instr;
                        w_count  = 2'd2;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        w_pc0    = r_pc1;
                        w_instr0 = r_instr1;
                        if (w_enq) begin
                            w_pc1    = r_fetch_pc;
                            w_instr1 = imem_instr;
                        end else begin
                            w_count = 2'd1;
                        end
                    end
                end
                default: w_count = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_pc0      <= 32'd0;
            r_instr0   <= 32'd0;
            r_pc1      <= 32'd0;
            r_instr1   <= 32'd0;
            r_count    <= 2'd0;
            r_valid    <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_fetch_pc <= w_fetch_pc;
            r_pc0      <= w_pc0;
            r_instr0   <= w_instr0;
            r_pc1      <= w_pc1;
            r_instr1   <= w_instr1;
            r_count    <= w_count;
            r_valid    <= (w_count != 2'd0);
            r_fault    <= w_fault;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_cnt, r_stall_cnt;
    logic        w_stall;

    // A stall is a full buffer that neither drains nor gets flushed this edge.
    assign w_stall   = (r_count == 2'd2) && !w_pop && !redirect_valid;
    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            if (w_enq) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Self-checking bench for imem_fetch_unit: directed scenarios plus random traffic against a queue-based reference model.
module tb_imem_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif

    logic [31:0] rom [2048];
    assign imem_instr = rom[imem_addr];

    imem_fetch_unit #(.RESET_PC(RESET_PC), .ADDR_W(11)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a FIFO of {pc, instr} pairs, the fetch PC and the sticky fault.
    logic [63:0] modelQ [$];
    logic [31:0] modelPc;
    logic        modelFault;
    logic [31:0] modelFetchCnt, modelStallCnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        modelPc       = RESET_PC;
        modelFault    = 1'b0;
        modelFetchCnt = 32'd0;
        modelStallCnt = 32'd0;
    endtask

    task automatic checkOutput();
        logic [63:0] head;
        check("out_valid", {31'd0, out_valid}, {31'd0, modelQ.size() != 0});
        check("fault", {31'd0, fault}, {31'd0, modelFault});
        check("imem_addr", {21'd0, imem_addr}, {21'd0, modelPc[12:2]});
        if (modelQ.size() != 0) begin
            head = modelQ[0];
            check("out_pc", out_pc, head[63:32]);
            check("out_instr", out_instr, head[31:0]);
        end
`ifdef FETCH_PERF_EN
        check("fetch_cnt", fetch_cnt, modelFetchCnt);
        check("stall_cnt", stall_cnt, modelStallCnt);
`endif
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic applyStimulus(input logic redir, input logic [31:0] target, input logic rdy);
        logic pop;
        redirect_valid = redir;
        redirect_pc    = target;
        out_ready      = rdy;
        pop = (modelQ.size() != 0) && rdy;
        if (redir) begin
            modelQ.delete();
            modelPc    = target;
            modelFault = (target[1:0] != 2'b00);
        end else begin
            if (modelQ.size() == 2 && !pop) modelStallCnt++;
            if (pop) void'(modelQ.pop_front());
            if (!modelFault && modelQ.size() < 2) begin
                modelQ.push_back({modelPc, rom[modelPc[12:2]]});
                modelPc = modelPc + 32'd4;
                modelFetchCnt++;
            end
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Assert reset away from an edge, check the immediate flush, release at the next negedge.
    task automatic pulseReset();
        #2;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        #1;
        modelReset();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_addr", {21'd0, imem_addr}, {21'd0, RESET_PC[12:2]});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b0;
        for (int i = 0; i < 2048; i++) rom[i] = i;
        @(negedge clk);
        pulseReset();

        $display("[TB] streaming from reset");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b1);
            if (i == 0) check("first_pc", out_pc, RESET_PC);
        end
        check("stream_instr", out_instr, 32'd5);

        $display("[TB] back-pressure after reset");
        pulseReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'd0, 1'b0);
        check("stall_head", out_pc, RESET_PC);
        check("stall_addr", {21'd0, imem_addr}, 32'd2);

        $display("[TB] redirect during transfer");
        applyStimulus(1'b1, 32'h0040_0100, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b1);
        check("redir_pc", out_pc, 32'h0040_0100);
        check("redir_instr", out_instr, 32'd64);

        $display("[TB] misaligned redirect");
        applyStimulus(1'b1, 32'h0040_0102, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b1);
        applyStimulus(1'b1, 32'h0040_0000, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b1);
        check("resume_instr", out_instr, 32'd0);

        $display("[TB] ROM index wrap");
        applyStimulus(1'b1, 32'h0040_1FFC, 1'b1);
        check("wrap_addr_hi", {21'd0, imem_addr}, 32'd2047);
        applyStimulus(1'b0, 32'd0, 1'b1);
        check("wrap_addr_lo", {21'd0, imem_addr}, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1);
        check("wrap_pc", out_pc, 32'h0040_2000);

        $display("[TB] reset while full");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'd0, 1'b0);
        pulseReset();
        applyStimulus(1'b0, 32'd0, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 2048; i++) rom[i] = $urandom;
        for (int i = 0; i < 400; i++) begin
            logic        redir;
            logic [31:0] target;
            redir  = ($urandom_range(0, 9) == 0);
            target = $urandom;
            if ($urandom_range(0, 4) != 0) target[1:0] = 2'b00;
            applyStimulus(redir, target, 1'($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
